// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester memory arbiter with a single registered memory port.
//
// Requester 0 is the CPU, requester 1 is the DMA/blitter. A request seen in IDLE
// is latched onto the memory port and held through BUSY until mem_ready_in or a
// timeout. The following DONE cycle pulses ack_out for the winner.
//
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to alternate grants on a tie
// (req_in == 2'b11). Without it, requester 0 always wins ties.
//
// Ports:
//   clk_in        rising-edge clock
//   rst_in        synchronous active-high reset
//   req_in[1:0]   per-requester request, held until ack
//   we_in[1:0]    per-requester write enable
//   addr0/1_in    request addresses
//   wdata0/1_in   write data
//   ack_out[1:0]  one-cycle completion pulse per requester
//   err_out       access timed out (valid with ack_out)
//   rdata_out     read data (valid with ack_out, 0 for writes and timeouts)
//   mem_*_out     registered memory command
//   mem_ready_in  memory completion, mem_rdata_in valid in the same cycle
//   grant_out     index of the current owner
//   busy_out      high outside IDLE
module mem_arbiter #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [1:0]        req_in,
  input  logic [1:0]        we_in,
  input  logic [ADDR_W-1:0] addr0_in,
  input  logic [ADDR_W-1:0] addr1_in,
  input  logic [DATA_W-1:0] wdata0_in,
  input  logic [DATA_W-1:0] wdata1_in,
  output logic [1:0]        ack_out,
  output logic              err_out,
  output logic [DATA_W-1:0] rdata_out,
  output logic              mem_req_out,
  output logic              mem_we_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_wdata_out,
  input  logic              mem_ready_in,
  input  logic [DATA_W-1:0] mem_rdata_in,
  output logic              grant_out,
  output logic              busy_out
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              state_q, state_d;
  logic                grant_q, grant_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                winner;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  // On a tie, hand the port to whoever did not get it last time.
  always_comb begin
    if (req_in == 2'b11) begin
      winner = ~last_grant_q;
    end else begin
      winner = ~req_in[0];
    end
  end
`else
  // Requester 0 wins whenever it is requesting.
  always_comb begin
    winner = ~req_in[0];
  end
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (req_in != 2'b00) begin
          grant_d     = winner;
          mem_req_d   = 1'b1;
          mem_we_d    = we_in[winner];
          mem_addr_d  = winner ? addr1_in : addr0_in;
          mem_wdata_d = winner ? wdata1_in : wdata0_in;
          cnt_d       = '0;
          state_d     = StBusy;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_d = winner;
`endif
        end
      end
      StBusy: begin
        // Ready takes priority so a response on the final cycle is not an error.
        if (mem_ready_in) begin
          rdata_d   = mem_we_q ? '0 : mem_rdata_in;
          err_d     = 1'b0;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = StDone;
        end else if (cnt_q == CntLast) begin
          rdata_d   = '0;
          err_d     = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      grant_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  always_comb begin
    ack_out   = 2'b00;
    err_out   = 1'b0;
    rdata_out = '0;
    if (state_q == StDone) begin
      ack_out   = grant_q ? 2'b10 : 2'b01;
      err_out   = err_q;
      rdata_out = rdata_q;
    end
  end

  assign mem_req_out   = mem_req_q;
  assign mem_we_out    = mem_we_q;
  assign mem_addr_out  = mem_addr_q;
  assign mem_wdata_out = mem_wdata_q;
  assign grant_out     = grant_q;
  assign busy_out      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scoreboard of expected acks plus a
// memory responder that also checks the command stays constant while BUSY.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 64;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b1;
  logic [1:0]        req_in = '0;
  logic [1:0]        we_in = '0;
  logic [ADDR_W-1:0] addr0_in = '0;
  logic [ADDR_W-1:0] addr1_in = '0;
  logic [DATA_W-1:0] wdata0_in = '0;
  logic [DATA_W-1:0] wdata1_in = '0;
  logic [1:0]        ack_out;
  logic              err_out;
  logic [DATA_W-1:0] rdata_out;
  logic              mem_req_out;
  logic              mem_we_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic [DATA_W-1:0] mem_wdata_out;
  logic              mem_ready_in = 1'b0;
  logic [DATA_W-1:0] mem_rdata_in = '0;
  logic              grant_out;
  logic              busy_out;

  mem_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .req_in       (req_in),
    .we_in        (we_in),
    .addr0_in     (addr0_in),
    .addr1_in     (addr1_in),
    .wdata0_in    (wdata0_in),
    .wdata1_in    (wdata1_in),
    .ack_out      (ack_out),
    .err_out      (err_out),
    .rdata_out    (rdata_out),
    .mem_req_out  (mem_req_out),
    .mem_we_out   (mem_we_out),
    .mem_addr_out (mem_addr_out),
    .mem_wdata_out(mem_wdata_out),
    .mem_ready_in (mem_ready_in),
    .mem_rdata_in (mem_rdata_in),
    .grant_out    (grant_out),
    .busy_out     (busy_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [1:0]        ack;
    logic              err;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int checks = 0;
  int failures = 0;

  // Memory model / expected command
  int                mem_lat = -1;
  int                busy_idx = 0;
  logic [DATA_W-1:0] mem_data = '0;
  logic              exp_we = 1'b0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [DATA_W-1:0] exp_wdata = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk_in) begin
    if (ack_out != 2'b00) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 64'(ack_out), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("ack", 64'(ack_out), 64'(mon_e.ack));
        check("err", 64'(err_out), 64'(mon_e.err));
        check("rdata", 64'(rdata_out), 64'(mon_e.rdata));
        check("grant", 64'(grant_out), 64'(mon_e.ack[1]));
      end
    end else begin
      check("quiet", 64'({err_out, rdata_out}), 64'd0);
    end
  end

  // Memory responder: ready on BUSY cycle index mem_lat (-1 = never)
  always @(negedge clk_in) begin
    mem_rdata_in = mem_data;
    if (mem_req_out) begin
      check("cmd_we", 64'(mem_we_out), 64'(exp_we));
      check("cmd_addr", 64'(mem_addr_out), 64'(exp_addr));
      check("cmd_wdata", 64'(mem_wdata_out), 64'(exp_wdata));
      mem_ready_in = (busy_idx == mem_lat);
      busy_idx++;
    end else begin
      mem_ready_in = 1'b0;
      busy_idx = 0;
    end
  end

  // Call just after a posedge with the DUT in IDLE.
  task automatic access(input logic [1:0] req, input logic [1:0] we,
                        input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                        input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                        input int lat, input logic [DATA_W-1:0] mdata, input bit perturb,
                        input logic [1:0] e_ack, input logic e_err,
                        input logic [DATA_W-1:0] e_rdata, input int e_lat);
    int n;
    bit got;
    logic w;
    w = e_ack[1];
    exp_we = we[w];
    exp_addr = w ? a1 : a0;
    exp_wdata = w ? d1 : d0;
    mem_lat = lat;
    mem_data = mdata;
    sb.push_back('{e_ack, e_err, e_rdata});
    req_in = req;
    we_in = we;
    addr0_in = a0;
    addr1_in = a1;
    wdata0_in = d0;
    wdata1_in = d1;
    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk_in);
      if (ack_out != 2'b00) begin
        got = 1'b1;
      end else begin
        n++;
        if (perturb && n == 2) begin
          req_in = 2'b11;
          we_in = ~we;
          addr0_in = ~a0;
          addr1_in = ~a1;
          wdata0_in = ~d0;
          wdata1_in = ~d1;
        end
      end
    end
    check("ack_seen", 64'(got), 64'd1);
    check("latency", 64'(n), 64'(e_lat));
    @(posedge clk_in);
    #1;
    req_in = 2'b00;
  endtask

  logic [1:0] tie_exp [4];
  int k;
  int n;

  initial begin
    // Reset state
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_ack", 64'(ack_out), 64'd0);
    check("rst_err_rdata", 64'({err_out, rdata_out}), 64'd0);
    check("rst_mem", 64'({mem_req_out, mem_we_out, mem_addr_out}), 64'd0);
    check("rst_wdata", 64'(mem_wdata_out), 64'd0);
    check("rst_grant_busy", 64'({grant_out, busy_out}), 64'd0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;

    // Read by requester 0, ready on first BUSY cycle
    access(2'b01, 2'b00, 16'h0010, 16'h0000, 32'h0, 32'h0, 0, 32'hDEADBEEF, 1'b0,
           2'b01, 1'b0, 32'hDEADBEEF, 2);

    // Write by requester 1, ready after 5 BUSY cycles, inputs disturbed mid-BUSY
    access(2'b10, 2'b10, 16'h0000, 16'h1234, 32'h0, 32'h55AA55AA, 4, 32'h13579BDF, 1'b1,
           2'b10, 1'b0, 32'h0, 6);

    // Held tie: four back-to-back reads
`ifdef MEM_ARB_ROUND_ROBIN_EN
    tie_exp[0] = 2'b01; tie_exp[1] = 2'b10; tie_exp[2] = 2'b01; tie_exp[3] = 2'b10;
`else
    tie_exp[0] = 2'b01; tie_exp[1] = 2'b01; tie_exp[2] = 2'b01; tie_exp[3] = 2'b01;
`endif
    for (int i = 0; i < 4; i++) sb.push_back('{tie_exp[i], 1'b0, 32'hA5A50F0F});
    exp_we = 1'b0;
    exp_addr = 16'h0040;
    exp_wdata = 32'h0;
    mem_lat = 0;
    mem_data = 32'hA5A50F0F;
    we_in = 2'b00;
    addr0_in = 16'h0040;
    addr1_in = 16'h0040;
    wdata0_in = '0;
    wdata1_in = '0;
    req_in = 2'b11;
    k = 0;
    n = 0;
    while (k < 4 && n < 100) begin
      @(negedge clk_in);
      n++;
      if (ack_out != 2'b00) k++;
    end
    check("tie_acks", 64'(k), 64'd4);
    check("tie_cycles", 64'(n), 64'd12);
    @(posedge clk_in);
    #1;
    req_in = 2'b00;

    // Timeout: ready never arrives
    access(2'b01, 2'b00, 16'h0200, 16'h0, 32'h0, 32'h0, -1, 32'hFFFFFFFF, 1'b0,
           2'b01, 1'b1, 32'h0, 2 + TIMEOUT - 1);
    // Ready on the last BUSY cycle completes normally
    access(2'b01, 2'b00, 16'h0204, 16'h0, 32'h0, 32'h0, TIMEOUT - 1, 32'hCAFEF00D, 1'b0,
           2'b01, 1'b0, 32'hCAFEF00D, 2 + TIMEOUT - 1);

    // Reset in the third BUSY cycle
    exp_we = 1'b0;
    exp_addr = 16'h0100;
    exp_wdata = 32'h0;
    mem_lat = -1;
    addr0_in = 16'h0100;
    wdata0_in = '0;
    we_in = 2'b00;
    req_in = 2'b01;
    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    req_in = 2'b00;
    @(negedge clk_in);
    check("pre_rst_busy", 64'({busy_out, mem_req_out}), 64'd3);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    @(negedge clk_in);
    check("post_rst_mem_req", 64'(mem_req_out), 64'd0);
    check("post_rst_busy", 64'(busy_out), 64'd0);
    check("post_rst_ack", 64'(ack_out), 64'd0);
    repeat (3) @(posedge clk_in);
    #1;
    // First tie after reset goes to requester 0
    access(2'b11, 2'b00, 16'h0300, 16'h0304, 32'h0, 32'h0, 1, 32'h0BADF00D, 1'b0,
           2'b01, 1'b0, 32'h0BADF00D, 3);

    repeat (3) @(posedge clk_in);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001: Parameter ADDR_W, default 16, is the address width of requesters and memory port.
REQ-002: Parameter DATA_W, default 32, is the data width of requesters and memory port.
REQ-003: Parameter TIMEOUT, default 64, is the maximum number of BUSY cycles spent waiting for mem_ready.
REQ-004: clk_in  input  1  is the single clock; all logic is rising-edge.
REQ-005: rst_in  input  1  is the reset; synchronous, active-high.
REQ-006: req_in  input  2  is the request per requester (bit 0 = CPU, bit 1 = DMA/blitter); held high until ack.
REQ-007: we_in  input  2  is the write enable per requester.
REQ-008: addr0_in, addr1_in  input  ADDR_W  are the request addresses.
REQ-009: wdata0_in, wdata1_in  input  DATA_W  are the write data.
REQ-010: ack_out  output  2  is a one-cycle completion pulse per requester.
REQ-011: err_out  output  1  is high with ack_out when the access timed out.
REQ-012: rdata_out  output  DATA_W  is the read data, valid while any ack_out bit is high.
REQ-013: mem_req_out, mem_we_out  output  1  are the memory-side request and write enable.
REQ-014: mem_addr_out  output  ADDR_W  and mem_wdata_out  output  DATA_W  are the memory-side command.
REQ-015: mem_ready_in  input  1  is memory completion; mem_rdata_in  input  DATA_W  is valid in the same cycle.
REQ-016: grant_out  output  1  is the index of the current owner; busy_out  output  1  is high outside IDLE.

Function
REQ-017: The FSM SHALL have states IDLE, BUSY, DONE.
REQ-018: IDLE: if req_in != 0, the block SHALL latch winner index, we, addr and wdata, then go to BUSY; otherwise it stays in IDLE.
REQ-019: BUSY: mem_req_out SHALL be 1 with the latched command held constant; mem_* outputs SHALL be registered.
REQ-020: BUSY with mem_ready_in=1: the block SHALL capture mem_rdata_in, go to DONE, and drop mem_req_out at that edge.
REQ-021: DONE: the block SHALL assert ack_out[winner] for exactly one cycle, then go to IDLE.
REQ-022: Minimum latency SHALL be 2 cycles from req sampled in IDLE to ack (cycle 0 IDLE, cycle 1 BUSY with ready, cycle 2 ack).
REQ-023: A requester SHALL drop req or present a new command in the cycle after ack; the IDLE cycle after DONE re-samples req_in, giving back-to-back throughput of one access per 3 cycles.
REQ-024: A BUSY-cycle counter SHALL clear on entry to BUSY; if it reaches TIMEOUT-1 with mem_ready_in=0, the block SHALL go to DONE with err_out=1 and rdata_out=0.
REQ-025: mem_ready_in=1 on the timeout cycle SHALL complete normally with err_out=0.
REQ-026: For write accesses, rdata_out SHALL be 0 during ack.
REQ-027: Changes on req/addr/wdata inputs during BUSY or DONE SHALL NOT affect the latched command.
REQ-028: Outside DONE, ack_out, err_out and rdata_out SHALL be 0.

Reset
REQ-029: rst_in=1 SHALL force IDLE, mem_req_out=0, mem_we_out=0, mem_addr_out=0, mem_wdata_out=0, ack_out=0, err_out=0, rdata_out=0, grant_out=0, busy_out=0, and timeout counter=0 at the next edge.
REQ-030: Reset mid-BUSY or mid-DONE SHALL abort without an ack; last_grant SHALL reset to 1, so requester 0 wins the first tie.

Configuration
REQ-031: With MEM_ARB_ROUND_ROBIN_EN defined, a tie (req_in=2'b11) SHALL grant the requester not in last_grant, and last_grant SHALL update on every grant.
REQ-032: Without MEM_ARB_ROUND_ROBIN_EN, requester 0 SHALL always win ties, and last_grant logic is absent.

Verification
REQ-033: Reset, then req_in=01, read addr 0x0010, mem_ready on first BUSY cycle with rdata 0xDEADBEEF -> ack_out=01 two cycles after the req is sampled, rdata_out=0xDEADBEEF, err_out=0.
REQ-034: req_in=10, write addr 0x1234 data 0x55AA55AA, ready after 5 cycles -> mem_we_out=1 and command stable for 5 cycles, ack_out=10, rdata_out=0.
REQ-035: req_in=11 held for 4 accesses with round-robin defined -> grants 0,1,0,1; macro undefined -> grants 0,0,0,0.
REQ-036: mem_ready_in held 0 with TIMEOUT=64 -> mem_req_out high for 64 cycles, then ack with err_out=1 and rdata_out=0; in a second run, ready on cycle 64 -> err_out=0.
REQ-037: rst_in asserted in the third BUSY cycle -> next edge mem_req_out=0, no ack; after release, tie req_in=11 grants requester 0.
